// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//
// Operand sequencer and result-capture stage for a W-bit registered ALU.
// Operand A with its opcode, then operand B, arrive over a valid/ready word
// stream. The block presents op/A/B to the ALU for one execute cycle, captures
// the registered ALU result and flag one cycle later, and holds them on a
// valid/ready output port until the consumer takes them.
//
// Configuration macro:
//   ALU_SEQ_CHAIN_EN - when defined, an accepted result is copied back into
//                      operand A and the next input word is taken as operand
//                      B (accumulator chaining). Undefined by default.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready       input word handshake
//   in_data [W-1:0]         operand value
//   in_op   [2:0]           opcode (000 add, 001 sub, 010 and, 011 or,
//                           100 not, 101 xor); 110/111 are rejected
//   alu_s/alu_a/alu_b       opcode and operands driven to the ALU
//   alu_result/alu_f        registered ALU result and flag
//   out_valid/out_ready     result handshake
//   out_result/out_flag     captured result and flag
//   op_err                  one-cycle pulse after an illegal opcode is dropped
//   op_cnt  [CNT_W-1:0]     completed operations, wraps
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
    parameter int W     = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [2:0]       in_op,
    output logic [2:0]       alu_s,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    input  logic [W-1:0]     alu_result,
    input  logic [1:0]       alu_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [1:0]       out_flag,
    output logic             op_err,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [2:0] {
        S_LOAD_A = 3'd0,
        S_LOAD_B = 3'd1,
        S_EXEC   = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Highest legal opcode (xor); 110 and 111 are rejected.
    localparam logic [2:0] OP_MAX = 3'b101;

    state_t           r_state;
    state_t           w_next_state;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [2:0]       r_op;
    logic [W-1:0]     r_out_result;
    logic [1:0]       r_out_flag;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_op_err;
    logic [CNT_W-1:0] r_op_cnt;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_op_legal;

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_op_legal = (in_op <= OP_MAX);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment first means every path assigns
    // w_next_state, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD_A: begin
                if (w_in_fire && w_op_legal) begin
                    w_next_state = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
`ifdef ALU_SEQ_CHAIN_EN
                // A word carrying a different, illegal opcode is dropped.
                if (w_in_fire && ((in_op == r_op) || w_op_legal)) begin
                    w_next_state = S_EXEC;
                end
`else
                if (w_in_fire) begin
                    w_next_state = S_EXEC;
                end
`endif
            end
            S_EXEC: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                if (w_out_fire) begin
`ifdef ALU_SEQ_CHAIN_EN
                    w_next_state = S_LOAD_B;
`else
                    w_next_state = S_LOAD_A;
`endif
                end
            end
            default: begin
                w_next_state = S_LOAD_A;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered handshake outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_out_result <= '0;
            r_out_flag   <= 2'b00;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_op_err     <= 1'b0;
            r_op_cnt     <= '0;
        end else begin
            r_op_err <= 1'b0;

            case (r_state)
                S_LOAD_A: begin
                    if (w_in_fire) begin
                        if (w_op_legal) begin
                            r_a  <= in_data;
                            r_op <= in_op;
                        end else begin
                            r_op_err <= 1'b1;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (w_in_fire) begin
`ifdef ALU_SEQ_CHAIN_EN
                        if (in_op == r_op) begin
                            r_b <= in_data;
                        end else if (w_op_legal) begin
                            r_op <= in_op;
                            r_b  <= in_data;
                        end else begin
                            r_op_err <= 1'b1;
                        end
`else
                        r_b <= in_data;
`endif
                    end
                end
                S_WAIT: begin
                    // The ALU sampled op/A/B at the end of EXEC, so its
                    // registered outputs are valid throughout this cycle.
                    r_out_result <= alu_result;
                    r_out_flag   <= alu_f;
                    r_op_cnt     <= r_op_cnt + CNT_W'(1);
                end
                S_DONE: begin
`ifdef ALU_SEQ_CHAIN_EN
                    if (w_out_fire) begin
                        r_a <= r_out_result;
                    end
`endif
                end
                default: begin
                end
            endcase

            // Handshake flags are registered copies of the next state, so
            // in_ready never depends combinationally on in_valid.
            r_in_ready  <= (w_next_state == S_LOAD_A) || (w_next_state == S_LOAD_B);
            r_out_valid <= (w_next_state == S_DONE);
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flag   = r_out_flag;
    assign op_err     = r_op_err;
    assign op_cnt     = r_op_cnt;
    assign alu_s      = r_op;
    assign alu_a      = r_a;
    assign alu_b      = r_b;

endmodule
